reg_cdc_src_ctrl: RTL

// - Source-side (software/bus-domain) controller for a register CDC handshake.
// - Other end of the destination-side arbiter: accepts bus writes, issues a level request
//   and holds it until ack, and holds the software-visible copy of the register.
// - Folds hardware-initiated update pulses from the destination into that copy.
// - Single clock domain: the req/ack/update synchronisers sit outside this block.

---
 rtl/reg_cdc_pkg.sv | 7 +
 rtl/reg_cdc_src_timer.sv | 25 ++
 rtl/reg_cdc_src_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/reg_cdc_pkg.sv
// reg_cdc_pkg: types shared by the source-side controller and the destination-side arbiter.
//   state_e   - source handshake state (idle / waiting for ack)
//   req_sel_e - arbiter request select (software vs hardware update)
package reg_cdc_pkg;
    typedef enum logic [0:0] {StIdle = 1'b0, StWait = 1'b1} state_e;
    typedef enum logic [0:0] {SelSwReq = 1'b0, SelHwReq = 1'b1} req_sel_e;
endpackage

// File: rtl/reg_cdc_src_timer.sv
// reg_cdc_src_timer: handshake timeout counter.
//   clk_i, rst_ni - clock, async active-low reset
//   clr_i         - restart the count (transaction accepted)
//   en_i          - count this cycle (waiting for ack)
//   expired_o     - count has reached TimeoutCycles-1
module reg_cdc_src_timer #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign expired_o = cnt_q == CntW'(TimeoutCycles - 1);
endmodule

// File: rtl/reg_cdc_src_ctrl.sv
// reg_cdc_src_ctrl: source-side controller of a register CDC handshake.
//   clk_i, rst_ni        - clock, async active-low reset
//   req_i, we_i, wd_i    - bus access (valid, write, write data)
//   ready_o, rdata_o     - access accepted, software-visible register value
//   err_o                - one-cycle timeout pulse
//   src_req_o, src_wd_o  - level request and its data toward the destination
//   src_ack_i            - destination completed the software write
//   src_update_i, dst_qs_i - destination hardware changed the register to dst_qs_i
// Optional macro REG_CDC_SRC_TIMEOUT_EN: abort a write after TimeoutCycles without ack.
module reg_cdc_src_ctrl
    import reg_cdc_pkg::*;
#(
    parameter int unsigned          DataWidth     = 32,
    parameter logic [DataWidth-1:0] ResetVal      = '0,
    parameter int unsigned          TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [DataWidth-1:0] wd_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    output logic                 src_req_o,
    output logic [DataWidth-1:0] src_wd_o,
    input  logic                 src_ack_i,
    input  logic                 src_update_i,
    input  logic [DataWidth-1:0] dst_qs_i
);
    state_e               state_q, state_d;
    logic [DataWidth-1:0] src_q, src_d, wd_q, wd_d;
    logic                 err_q, err_d;
    logic                 in_wait, wr_acc, timeout;

    assign in_wait = state_q == StWait;
    assign wr_acc  = !in_wait && req_i && we_i;

`ifdef REG_CDC_SRC_TIMEOUT_EN
    reg_cdc_src_timer #(.TimeoutCycles(TimeoutCycles)) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (wr_acc),
        .en_i     (in_wait),
        .expired_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // The ack beats a same-cycle hardware update: the software write lands last in the destination.
    always_comb begin
        state_d = in_wait ? ((src_ack_i || timeout) ? StIdle : StWait) : (wr_acc ? StWait : StIdle);
        src_d   = (in_wait && src_ack_i) ? wd_q : src_update_i ? dst_qs_i : src_q;
        wd_d    = wr_acc ? wd_i : wd_q;
        err_d   = in_wait && timeout && !src_ack_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= ResetVal;
            wd_q  <= '0;
        end else begin
            src_q <= src_d;
            wd_q  <= wd_d;
        end
    end

    assign ready_o   = !in_wait;
    assign src_req_o = in_wait;
    assign src_wd_o  = wd_q;
    assign rdata_o   = src_q;
    assign err_o     = err_q;
endmodule
